// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch
// resolution and target computation, followed by the EX/MEM pipeline register.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            regwrite_e,
  input  logic [1:0]      result_src_e,
  input  logic            memwrite_e,
  input  logic            jump_e,
  input  logic            branch_e,
  input  logic            branch_ne_e,
  input  logic [2:0]      alu_control_e,
  input  logic            alu_src_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus_4_e,
  input  logic [4:0]      rd_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] mem_alu_result_m,
  input  logic [XLEN-1:0] result_w,
  input  logic            stall_m,
  input  logic            flush_m,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            ex_mem_regwrite,
  output logic            ex_mem_memwrite,
  output logic [1:0]      ex_mem_result_src,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_writedata,
  output logic [XLEN-1:0] ex_mem_pc_plus_4,
  output logic [4:0]      ex_mem_rd
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
  logic            zero;

  // Select 11 is unused by the hazard unit and falls back to the register file value.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] wb,
                                              input logic [XLEN-1:0] mem);
    case (sel)
      2'b01:   return wb;
      2'b10:   return mem;
      default: return rf;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [2:0] op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SHW-1:0]         shamt;
    sa    = signed'(a);
    sb    = signed'(b);
    shamt = b[SHW-1:0];
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return (sa < sb) ? XLEN'(1) : XLEN'(0);
      3'b110:  return a << shamt;
      default: return a >> shamt;
    endcase
  endfunction

  // EX combinational datapath
  always_comb begin
    src_a       = fwd_sel(forward_a_e, rd1_e, result_w, mem_alu_result_m);
    fwd_b       = fwd_sel(forward_b_e, rd2_e, result_w, mem_alu_result_m);
    src_b       = alu_src_e ? imm_ext_e : fwd_b;
    alu_result  = alu(alu_control_e, src_a, src_b);
    zero        = (alu_result == '0);
    pc_src_e    = jump_e | (branch_e & (zero ^ branch_ne_e));
    pc_target_e = pc_e + imm_ext_e;
  end

  // EX/MEM register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush_m) begin
      ex_mem_regwrite   <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      ex_mem_result_src <= 2'b00;
      ex_mem_alu_result <= '0;
      ex_mem_writedata  <= '0;
      ex_mem_pc_plus_4  <= '0;
      ex_mem_rd         <= 5'd0;
    end else if (!stall_m) begin
      ex_mem_regwrite   <= regwrite_e;
      ex_mem_memwrite   <= memwrite_e;
      ex_mem_result_src <= result_src_e;
      ex_mem_alu_result <= alu_result;
      ex_mem_writedata  <= fwd_b;
      ex_mem_pc_plus_4  <= pc_plus_4_e;
      ex_mem_rd         <= rd_e;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, branch resolution,
// stall/flush priority and asynchronous reset of the EX/MEM register.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_e, memwrite_e, jump_e, branch_e, branch_ne_e, alu_src_e;
  logic [1:0]  result_src_e, forward_a_e, forward_b_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus_4_e, mem_alu_result_m, result_w;
  logic [4:0]  rd_e;
  logic        stall_m, flush_m;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        ex_mem_regwrite, ex_mem_memwrite;
  logic [1:0]  ex_mem_result_src;
  logic [31:0] ex_mem_alu_result, ex_mem_writedata, ex_mem_pc_plus_4;
  logic [4:0]  ex_mem_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .regwrite_e(regwrite_e), .result_src_e(result_src_e), .memwrite_e(memwrite_e),
    .jump_e(jump_e), .branch_e(branch_e), .branch_ne_e(branch_ne_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e), .rd_e(rd_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_alu_result_m(mem_alu_result_m), .result_w(result_w),
    .stall_m(stall_m), .flush_m(flush_m),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_result_src(ex_mem_result_src), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_writedata(ex_mem_writedata), .ex_mem_pc_plus_4(ex_mem_pc_plus_4),
    .ex_mem_rd(ex_mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".regwrite"},   32'(ex_mem_regwrite),   32'd0);
    chk({tag, ".memwrite"},   32'(ex_mem_memwrite),   32'd0);
    chk({tag, ".result_src"}, 32'(ex_mem_result_src), 32'd0);
    chk({tag, ".alu_result"}, ex_mem_alu_result,      32'd0);
    chk({tag, ".writedata"},  ex_mem_writedata,       32'd0);
    chk({tag, ".pc_plus_4"},  ex_mem_pc_plus_4,       32'd0);
    chk({tag, ".rd"},         32'(ex_mem_rd),         32'd0);
  endtask

  initial begin
    reset = 1'b1;
    regwrite_e = 0; memwrite_e = 0; jump_e = 0; branch_e = 0; branch_ne_e = 0;
    alu_src_e = 0; result_src_e = 0; forward_a_e = 0; forward_b_e = 0;
    alu_control_e = 0; rd1_e = 0; rd2_e = 0; imm_ext_e = 0; pc_e = 0;
    pc_plus_4_e = 0; mem_alu_result_m = 0; result_w = 0; rd_e = 0;
    stall_m = 0; flush_m = 0;

    // Reset state
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;

    // 1. ADD with forwarding: srcA from MEM (7), fwdB from WB (9)
    rd1_e = 32'd5; rd2_e = 32'd3; mem_alu_result_m = 32'd7; result_w = 32'd9;
    forward_a_e = 2'b10; forward_b_e = 2'b01; alu_control_e = 3'b000;
    regwrite_e = 1; rd_e = 5'd12; pc_plus_4_e = 32'h44;
    step();
    chk("add_fwd.alu_result", ex_mem_alu_result, 32'd16);
    chk("add_fwd.writedata",  ex_mem_writedata,  32'd9);
    chk("add_fwd.rd",         32'(ex_mem_rd),    32'd12);
    chk("add_fwd.pc_plus_4",  ex_mem_pc_plus_4,  32'h44);

    // Forward select 11 falls back to register file
    forward_a_e = 2'b11; forward_b_e = 2'b11;
    step();
    chk("fwd11.alu_result", ex_mem_alu_result, 32'd8);
    chk("fwd11.writedata",  ex_mem_writedata,  32'd3);

    // 2. BEQ taken / BNE not taken
    rd1_e = 32'h1234; rd2_e = 32'h1234; forward_a_e = 0; forward_b_e = 0;
    alu_control_e = 3'b001; branch_e = 1; branch_ne_e = 0;
    pc_e = 32'h100; imm_ext_e = 32'hFFFF_FFF0;
    #1;
    chk("beq_taken.pc_src", 32'(pc_src_e), 32'd1);
    chk("beq.pc_target",    pc_target_e,   32'h0000_00F0);
    branch_ne_e = 1;
    #1;
    chk("bne_not_taken.pc_src", 32'(pc_src_e), 32'd0);
    rd2_e = 32'h1235;
    #1;
    chk("bne_taken.pc_src", 32'(pc_src_e), 32'd1);
    branch_e = 0; jump_e = 1;
    #1;
    chk("jal.pc_src", 32'(pc_src_e), 32'd1);
    jump_e = 0;
    #1;
    chk("no_branch.pc_src", 32'(pc_src_e), 32'd0);

    // 3. Signed SLT and shifts via immediate
    alu_src_e = 1; rd1_e = 32'hFFFF_FFFF; imm_ext_e = 32'd1; alu_control_e = 3'b101;
    step();
    chk("slt_signed", ex_mem_alu_result, 32'd1);
    rd1_e = 32'd1; imm_ext_e = 32'h8000_0000;
    step();
    chk("slt_false", ex_mem_alu_result, 32'd0);
    rd1_e = 32'd1; imm_ext_e = 32'h21; alu_control_e = 3'b110;
    step();
    chk("sll_mask", ex_mem_alu_result, 32'd2);
    rd1_e = 32'h8000_0000; imm_ext_e = 32'd31; alu_control_e = 3'b111;
    step();
    chk("srl_31", ex_mem_alu_result, 32'd1);
    rd1_e = 32'hF0F0_00FF; imm_ext_e = 32'h0F0F_0F0F; alu_control_e = 3'b100;
    step();
    chk("xor", ex_mem_alu_result, 32'hFFFF_0FF0);
    alu_control_e = 3'b010;
    step();
    chk("and", ex_mem_alu_result, 32'h0000_000F);
    alu_control_e = 3'b011;
    step();
    chk("or", ex_mem_alu_result, 32'hFFFF_0FFF);

    // 4. Stall holds, flush beats stall
    alu_src_e = 0; alu_control_e = 3'b000; rd1_e = 32'd1; rd2_e = 32'd2;
    regwrite_e = 1; rd_e = 5'd5; result_src_e = 2'b10; pc_plus_4_e = 32'h104;
    step();
    chk("load.regwrite",  32'(ex_mem_regwrite), 32'd1);
    chk("load.rd",        32'(ex_mem_rd),       32'd5);
    chk("load.alu_result", ex_mem_alu_result,   32'd3);
    stall_m = 1; rd_e = 5'd9; regwrite_e = 0; rd1_e = 32'd100; result_src_e = 2'b01;
    step();
    rd_e = 5'd10; rd2_e = 32'd77; pc_plus_4_e = 32'h200;
    step();
    chk("stall.regwrite",   32'(ex_mem_regwrite),   32'd1);
    chk("stall.rd",         32'(ex_mem_rd),         32'd5);
    chk("stall.alu_result", ex_mem_alu_result,      32'd3);
    chk("stall.writedata",  ex_mem_writedata,       32'd2);
    chk("stall.result_src", 32'(ex_mem_result_src), 32'd2);
    chk("stall.pc_plus_4",  ex_mem_pc_plus_4,       32'h104);
    flush_m = 1; regwrite_e = 1;
    step();
    chk_all_zero("flush");
    stall_m = 0; flush_m = 0;

    // 5. Asynchronous reset mid-cycle
    regwrite_e = 1; rd_e = 5'd7; rd1_e = 32'd10; rd2_e = 32'd20; pc_plus_4_e = 32'h300;
    result_src_e = 2'b00;
    step();
    chk("pre_reset.regwrite", 32'(ex_mem_regwrite), 32'd1);
    chk("pre_reset.alu_result", ex_mem_alu_result, 32'd30);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    #1 reset = 1'b0;
    step();
    chk("post_reset.regwrite",   32'(ex_mem_regwrite), 32'd1);
    chk("post_reset.rd",         32'(ex_mem_rd),       32'd7);
    chk("post_reset.alu_result", ex_mem_alu_result,    32'd30);

    // 6. Store path: address from immediate, data from forwarded rs2
    alu_src_e = 1; imm_ext_e = 32'd8; rd1_e = 32'h1000; rd2_e = 32'hDEAD;
    memwrite_e = 1; regwrite_e = 0; alu_control_e = 3'b000;
    step();
    chk("store.alu_result", ex_mem_alu_result,     32'h1008);
    chk("store.writedata",  ex_mem_writedata,      32'hDEAD);
    chk("store.memwrite",   32'(ex_mem_memwrite),  32'd1);
    chk("store.regwrite",   32'(ex_mem_regwrite),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
